// File: rtl/player_grid_mover_pkg.sv
// -----------------------------------------------------------------------------
// player_pkg
//   Shared types for the overworld player movement engine.
//   - facing_t      : sprite facing, encoded as the renderer expects
//                     (0=down, 1=up, 2=left, 3=right)
//   - mover_state_t : movement FSM states
//   - TILE_PX_DEFAULT : default tile edge in pixels
// -----------------------------------------------------------------------------
package player_pkg;

   typedef enum logic [1:0] {
      DIR_DOWN  = 2'd0,
      DIR_UP    = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } facing_t;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      QUERY = 2'd1,
      WALK  = 2'd2
   } mover_state_t;

   localparam int TILE_PX_DEFAULT = 16;

endpackage

// File: rtl/player_grid_mover_if.sv
// -----------------------------------------------------------------------------
// player_grid_mover_if
//   Collision lookup handshake between the mover and the tile-map lookup.
//   coll_req      : query valid, held with a stable coll_col/coll_row
//   coll_col/row  : target tile being asked about
//   coll_ack      : single-cycle response valid
//   coll_blocked  : target impassable, meaningful only with coll_ack
//   Modports: master = mover (issues queries), slave = lookup (answers).
// -----------------------------------------------------------------------------
interface player_grid_mover_if #(
   parameter int COL_W = 6,
   parameter int ROW_W = 6
);
   logic             coll_req;
   logic [COL_W-1:0] coll_col;
   logic [ROW_W-1:0] coll_row;
   logic             coll_ack;
   logic             coll_blocked;

   modport master (
      output coll_req, coll_col, coll_row,
      input  coll_ack, coll_blocked
   );

   modport slave (
      input  coll_req, coll_col, coll_row,
      output coll_ack, coll_blocked
   );
endinterface

// File: rtl/player_grid_mover_dir_arbiter.sv
// -----------------------------------------------------------------------------
// dir_arbiter
//   Combinational direction select and target tile computation.
//   Priority up > down > left > right.
//   Inputs : up/down/left/right buttons, current tile cur_col/cur_row
//   Outputs: any_dir   - at least one button held
//            dir       - selected facing
//            tgt_col/row - neighbouring tile in that direction
//            in_bounds - target lies inside the map (0 when no button)
// -----------------------------------------------------------------------------
module dir_arbiter
   import player_pkg::*;
#(
   parameter int MAP_COLS = 64,
   parameter int MAP_ROWS = 48,
   parameter int COL_W    = 6,
   parameter int ROW_W    = 6
) (
   input  logic             up,
   input  logic             down,
   input  logic             left,
   input  logic             right,
   input  logic [COL_W-1:0] cur_col,
   input  logic [ROW_W-1:0] cur_row,
   output logic             any_dir,
   output facing_t          dir,
   output logic [COL_W-1:0] tgt_col,
   output logic [ROW_W-1:0] tgt_row,
   output logic             in_bounds
);

   // NOTE: every output gets a default before the priority chain so that no
   // path leaves a value unassigned, which would otherwise infer a latch.
   always_comb begin
      any_dir   = up | down | left | right;
      dir       = DIR_DOWN;
      tgt_col   = cur_col;
      tgt_row   = cur_row;
      in_bounds = 1'b0;
      // Edge tests happen before the +/-1 so the target never wraps into
      // the opposite side of the map.
      if (up) begin
         dir       = DIR_UP;
         in_bounds = (cur_row != '0);
         tgt_row   = cur_row - ROW_W'(1);
      end else if (down) begin
         dir       = DIR_DOWN;
         in_bounds = (cur_row != ROW_W'(MAP_ROWS - 1));
         tgt_row   = cur_row + ROW_W'(1);
      end else if (left) begin
         dir       = DIR_LEFT;
         in_bounds = (cur_col != '0);
         tgt_col   = cur_col - COL_W'(1);
      end else if (right) begin
         dir       = DIR_RIGHT;
         in_bounds = (cur_col != COL_W'(MAP_COLS - 1));
         tgt_col   = cur_col + COL_W'(1);
      end
   end

endmodule

// File: rtl/player_grid_mover.sv
// -----------------------------------------------------------------------------
// player_grid_mover
//   Smooth tile-grid player movement. On a frame tick in IDLE the held
//   direction turns the player; if the neighbouring tile is on the map the
//   collision lookup is queried, and a passable answer starts a walk of
//   STEP_PX pixels per frame until the whole tile is covered.
//   Ports:
//     vclk, reset        : pixel clock, synchronous active-high reset
//     hcount, vcount     : raster position; (0,0) is the frame tick
//     up/down/left/right : held direction buttons
//     coll               : collision lookup handshake (master side)
//     player_x/player_y  : sprite top-left in pixels
//     facing             : 0=down 1=up 2=left 3=right
//     moving             : high while walking
//     anim_frame         : walk cycle index
// -----------------------------------------------------------------------------
module player_grid_mover
   import player_pkg::*;
#(
   parameter int TILE_PX     = TILE_PX_DEFAULT,
   parameter int STEP_PX     = 2,
   parameter int MAP_COLS    = 64,
   parameter int MAP_ROWS    = 48,
   parameter int START_COL   = 0,
   parameter int START_ROW   = 5,
   parameter int ACK_TIMEOUT = 15
) (
   input  logic                vclk,
   input  logic                reset,
   input  logic [10:0]         hcount,
   input  logic [9:0]          vcount,
   input  logic                up,
   input  logic                down,
   input  logic                left,
   input  logic                right,
   player_grid_mover_if.master coll,
   output logic [10:0]         player_x,
   output logic [9:0]          player_y,
   output logic [1:0]          facing,
   output logic                moving,
   output logic [1:0]          anim_frame
);

   localparam int COL_W      = $clog2(MAP_COLS);
   localparam int ROW_W      = $clog2(MAP_ROWS);
   localparam int TILE_SHIFT = $clog2(TILE_PX);
   // Frames per animation frame: four animation frames span two tiles.
   localparam int ANIM_TICKS = (TILE_PX / (2 * STEP_PX) > 0) ? TILE_PX / (2 * STEP_PX) : 1;
   localparam int ACW        = (ANIM_TICKS > 1) ? $clog2(ANIM_TICKS) : 1;
   localparam int TOW        = $clog2(ACK_TIMEOUT + 1);

   localparam logic [10:0] STEP_X  = 11'(STEP_PX);
   localparam logic [9:0]  STEP_Y  = 10'(STEP_PX);
   localparam logic [10:0] START_X = 11'(START_COL) << TILE_SHIFT;
   localparam logic [9:0]  START_Y = 10'(START_ROW) << TILE_SHIFT;

   mover_state_t     state_q, state_d;
   facing_t          facing_q, facing_d;
   logic [COL_W-1:0] col_q, col_d, tgt_col_q, tgt_col_d;
   logic [ROW_W-1:0] row_q, row_d, tgt_row_q, tgt_row_d;
   logic [10:0]      x_q, x_d;
   logic [9:0]       y_q, y_d;
   logic [1:0]       anim_q, anim_d;
   logic [ACW-1:0]   anim_cnt_q, anim_cnt_d;
   logic [TOW-1:0]   to_cnt_q, to_cnt_d;

   logic             frame_tick;
   logic             arb_any, arb_ok;
   facing_t          arb_dir;
   logic [COL_W-1:0] arb_col;
   logic [ROW_W-1:0] arb_row;
   logic [10:0]      tgt_x;
   logic [9:0]       tgt_y;

   assign frame_tick = (hcount == '0) && (vcount == '0);
   assign tgt_x      = 11'(tgt_col_q) << TILE_SHIFT;
   assign tgt_y      = 10'(tgt_row_q) << TILE_SHIFT;

   dir_arbiter #(
      .MAP_COLS (MAP_COLS),
      .MAP_ROWS (MAP_ROWS),
      .COL_W    (COL_W),
      .ROW_W    (ROW_W)
   ) u_dir_arbiter (
      .up        (up),
      .down      (down),
      .left      (left),
      .right     (right),
      .cur_col   (col_q),
      .cur_row   (row_q),
      .any_dir   (arb_any),
      .dir       (arb_dir),
      .tgt_col   (arb_col),
      .tgt_row   (arb_row),
      .in_bounds (arb_ok)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before this edge; the combinational block below
   // uses blocking assignments so later lines see the freshly computed x_d/y_d.
   always_ff @(posedge vclk) begin
      if (reset) begin
         state_q    <= IDLE;
         facing_q   <= DIR_DOWN;
         col_q      <= COL_W'(START_COL);
         row_q      <= ROW_W'(START_ROW);
         tgt_col_q  <= COL_W'(START_COL);
         tgt_row_q  <= ROW_W'(START_ROW);
         x_q        <= START_X;
         y_q        <= START_Y;
         anim_q     <= '0;
         anim_cnt_q <= '0;
         to_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         facing_q   <= facing_d;
         col_q      <= col_d;
         row_q      <= row_d;
         tgt_col_q  <= tgt_col_d;
         tgt_row_q  <= tgt_row_d;
         x_q        <= x_d;
         y_q        <= y_d;
         anim_q     <= anim_d;
         anim_cnt_q <= anim_cnt_d;
         to_cnt_q   <= to_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      facing_d   = facing_q;
      col_d      = col_q;
      row_d      = row_q;
      tgt_col_d  = tgt_col_q;
      tgt_row_d  = tgt_row_q;
      x_d        = x_q;
      y_d        = y_q;
      anim_d     = anim_q;
      anim_cnt_d = anim_cnt_q;
      to_cnt_d   = to_cnt_q;

      case (state_q)
         IDLE: begin
            // Turning happens even when the target is off the map.
            if (frame_tick && arb_any) begin
               facing_d = arb_dir;
               if (arb_ok) begin
                  tgt_col_d = arb_col;
                  tgt_row_d = arb_row;
                  to_cnt_d  = '0;
                  state_d   = QUERY;
               end
            end
         end

         QUERY: begin
            // The ack is tested first so an ack on the final waiting cycle
            // still wins over the timeout.
            if (coll.coll_ack) begin
               to_cnt_d = '0;
               if (!coll.coll_blocked) begin
                  col_d      = tgt_col_q;
                  row_d      = tgt_row_q;
                  anim_d     = '0;
                  anim_cnt_d = '0;
                  state_d    = WALK;
               end else begin
                  state_d = IDLE;
               end
            end else if (to_cnt_q == TOW'(ACK_TIMEOUT - 1)) begin
               to_cnt_d = '0;
               state_d  = IDLE;
            end else begin
               to_cnt_d = to_cnt_q + TOW'(1);
            end
         end

         WALK: begin
            if (frame_tick) begin
               case (facing_q)
                  DIR_UP:    y_d = y_q - STEP_Y;
                  DIR_DOWN:  y_d = y_q + STEP_Y;
                  DIR_LEFT:  x_d = x_q - STEP_X;
                  default:   x_d = x_q + STEP_X;
               endcase
               if (x_d == tgt_x && y_d == tgt_y) begin
                  anim_d     = '0;
                  anim_cnt_d = '0;
                  state_d    = IDLE;
               end else if (anim_cnt_q == ACW'(ANIM_TICKS - 1)) begin
                  anim_cnt_d = '0;
                  anim_d     = anim_q + 2'd1;
               end else begin
                  anim_cnt_d = anim_cnt_q + ACW'(1);
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   assign coll.coll_req = (state_q == QUERY);
   assign coll.coll_col = tgt_col_q;
   assign coll.coll_row = tgt_row_q;
   assign player_x      = x_q;
   assign player_y      = y_q;
   assign facing        = facing_q;
   assign moving        = (state_q == WALK);
   assign anim_frame    = anim_q;

endmodule

// File: tb/tb_player_grid_mover.sv
// -----------------------------------------------------------------------------
// tb_player_grid_mover
//   Self-checking bench for player_grid_mover. Frame ticks are produced on
//   demand by driving hcount=vcount=0 for one cycle, with enough idle cycles
//   between ticks for any collision query to finish. A collision responder
//   answers each query after a programmable latency.
// -----------------------------------------------------------------------------
module tb_player_grid_mover;
   import player_pkg::*;

   localparam int TILE  = 16;
   localparam int STEP  = 2;
   localparam int COLS  = 64;
   localparam int ROWS  = 48;
   localparam int TO    = 15;
   localparam int GAP   = 24;
   localparam int AT    = TILE / (2 * STEP);
   localparam int WALKN = TILE / STEP;

   logic        vclk = 1'b0;
   logic        reset;
   logic [10:0] hcount;
   logic [9:0]  vcount;
   logic        up, down, left, right;
   logic [10:0] player_x;
   logic [9:0]  player_y;
   logic [1:0]  facing;
   logic        moving;
   logic [1:0]  anim_frame;

   player_grid_mover_if #(.COL_W(6), .ROW_W(6)) coll_bus ();

   player_grid_mover #(
      .TILE_PX(TILE), .STEP_PX(STEP), .MAP_COLS(COLS), .MAP_ROWS(ROWS),
      .START_COL(0), .START_ROW(5), .ACK_TIMEOUT(TO)
   ) dut (
      .vclk       (vclk),
      .reset      (reset),
      .hcount     (hcount),
      .vcount     (vcount),
      .up         (up),
      .down       (down),
      .left       (left),
      .right      (right),
      .coll       (coll_bus),
      .player_x   (player_x),
      .player_y   (player_y),
      .facing     (facing),
      .moving     (moving),
      .anim_frame (anim_frame)
   );

   always #5 vclk = ~vclk;

   int n_cmp  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      n_cmp++;
      if (actual !== expected) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   // Collision responder: acks on the (resp_lat+1)-th cycle of a request,
   // never when resp_lat < 0. Counts every cycle coll_req is seen high.
   int resp_lat  = -1;
   bit resp_blk  = 1'b0;
   int req_age   = 0;
   int req_total = 0;

   always @(negedge vclk) begin
      if (coll_bus.coll_req === 1'b1) begin
         req_total++;
         req_age++;
         if (resp_lat >= 0 && req_age == resp_lat + 1) begin
            coll_bus.coll_ack     = 1'b1;
            coll_bus.coll_blocked = resp_blk;
         end else begin
            coll_bus.coll_ack     = 1'b0;
            coll_bus.coll_blocked = 1'b0;
         end
      end else begin
         req_age               = 0;
         coll_bus.coll_ack     = 1'b0;
         coll_bus.coll_blocked = 1'b0;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge vclk);
         #1;
      end
   endtask

   task automatic set_btn(input logic [3:0] b);
      {up, down, left, right} = b;
   endtask

   // Idle raster keeps one coordinate at zero so only the true (0,0) ticks.
   task automatic idle_raster();
      if ($urandom_range(0, 1) == 0) begin
         hcount = 11'd0;
         vcount = 10'($urandom_range(1, 524));
      end else begin
         hcount = 11'($urandom_range(1, 799));
         vcount = 10'd0;
      end
   endtask

   task automatic tick_frame();
      hcount = 11'd0;
      vcount = 10'd0;
      cycles(1);
      idle_raster();
   endtask

   task automatic frame();
      tick_frame();
      cycles(GAP - 1);
   endtask

   typedef struct {
      logic [3:0] btn;   // {up, down, left, right}
      int         lat;   // ack latency, -1 = never
      bit         blk;
      int         face;
      int         req;   // expected coll_req-high cycles
      int         tcol;
      int         trow;
      int         ecol;  // tile after the record
      int         erow;
   } vec_t;

   vec_t tbl[9];
   int   anim_exp[8] = '{0, 0, 0, 1, 1, 1, 1, 0};

   // Reference model state (frame-level)
   int m_col, m_row, m_face, m_walk, m_steps, m_anim, m_fx, m_fy, m_dx, m_dy;

   initial begin
      int r0, pc, pr;

      tbl[0] = '{4'b0100,  0, 1'b1, 0,  1, 1, 6, 1, 5};
      tbl[1] = '{4'b1001,  1, 1'b0, 1,  2, 1, 4, 1, 4};
      tbl[2] = '{4'b0010, 14, 1'b0, 2, 15, 0, 4, 0, 4};
      tbl[3] = '{4'b0100, -1, 1'b0, 0, 15, 0, 5, 0, 4};
      tbl[4] = '{4'b0010,  0, 1'b0, 2,  0, 0, 0, 0, 4};
      tbl[5] = '{4'b1000,  5, 1'b1, 1,  6, 0, 3, 0, 4};
      tbl[6] = '{4'b0110,  3, 1'b0, 0,  4, 0, 5, 0, 5};
      tbl[7] = '{4'b0000,  0, 1'b0, 0,  0, 0, 0, 0, 5};
      tbl[8] = '{4'b0001, 15, 1'b0, 3, 15, 1, 5, 0, 5};

      reset  = 1'b1;
      hcount = 11'd1;
      vcount = 10'd0;
      set_btn(4'b0000);
      @(posedge vclk);
      #1;
      cycles(2);
      reset = 1'b0;

      // ---------------- reset state, idle frames ----------------
      check("reset_x", player_x, 0);
      check("reset_y", player_y, 80);
      check("reset_facing", facing, 0);
      check("reset_moving", moving, 0);
      check("reset_anim", anim_frame, 0);
      check("reset_req", coll_bus.coll_req, 0);
      r0 = req_total;
      repeat (3) frame();
      check("idle_x", player_x, 0);
      check("idle_y", player_y, 80);
      check("idle_req_cycles", req_total - r0, 0);

      // ---------------- walk right, frame by frame ----------------
      resp_lat = 2;
      resp_blk = 1'b0;
      set_btn(4'b0001);
      r0 = req_total;
      tick_frame();
      set_btn(4'b0000);  // released mid-query: latched target still used
      check("walk_facing", facing, 3);
      check("walk_req", coll_bus.coll_req, 1);
      check("walk_coll_col", coll_bus.coll_col, 1);
      check("walk_coll_row", coll_bus.coll_row, 5);
      cycles(GAP - 1);
      check("walk_req_cycles", req_total - r0, 3);
      check("walk_moving_start", moving, 1);
      check("walk_x_start", player_x, 0);
      for (int k = 1; k <= WALKN; k++) begin
         frame();
         check($sformatf("walk_x_%0d", k), player_x, 2 * k);
         check($sformatf("walk_anim_%0d", k), anim_frame, anim_exp[k-1]);
         check($sformatf("walk_moving_%0d", k), moving, (k < WALKN) ? 1 : 0);
      end
      check("walk_y_end", player_y, 80);

      // ---------------- table-driven single moves ----------------
      pc = 1;
      pr = 5;
      for (int i = 0; i < 9; i++) begin
         resp_lat = tbl[i].lat;
         resp_blk = tbl[i].blk;
         set_btn(tbl[i].btn);
         r0 = req_total;
         tick_frame();
         if (tbl[i].req > 0) begin
            check($sformatf("tbl%0d_coll_col", i), coll_bus.coll_col, tbl[i].tcol);
            check($sformatf("tbl%0d_coll_row", i), coll_bus.coll_row, tbl[i].trow);
         end
         cycles(GAP - 1);
         set_btn(4'b0000);
         check($sformatf("tbl%0d_facing", i), facing, tbl[i].face);
         check($sformatf("tbl%0d_req_cycles", i), req_total - r0, tbl[i].req);
         if (tbl[i].ecol != pc || tbl[i].erow != pr) begin
            check($sformatf("tbl%0d_moving", i), moving, 1);
            repeat (WALKN) frame();
         end
         check($sformatf("tbl%0d_x", i), player_x, tbl[i].ecol * TILE);
         check($sformatf("tbl%0d_y", i), player_y, tbl[i].erow * TILE);
         check($sformatf("tbl%0d_moving_end", i), moving, 0);
         pc = tbl[i].ecol;
         pr = tbl[i].erow;
      end

      // ---------------- timeout then fresh query with up held ----------------
      resp_lat = -1;
      set_btn(4'b1000);
      r0 = req_total;
      frame();
      check("to_req_cycles", req_total - r0, TO);
      check("to_req_low", coll_bus.coll_req, 0);
      check("to_y", player_y, 80);
      check("to_moving", moving, 0);
      tick_frame();
      check("to_fresh_req", coll_bus.coll_req, 1);
      check("to_fresh_row", coll_bus.coll_row, 4);
      cycles(GAP - 1);
      set_btn(4'b0000);

      // ---------------- reset mid-walk ----------------
      resp_lat = 0;
      resp_blk = 1'b0;
      set_btn(4'b0001);
      frame();
      set_btn(4'b0000);
      repeat (3) frame();
      check("rstw_x_before", player_x, 6);
      check("rstw_moving_before", moving, 1);
      reset  = 1'b1;
      hcount = 11'd0;
      vcount = 10'd0;
      set_btn(4'b0001);
      cycles(1);
      reset = 1'b0;
      idle_raster();
      set_btn(4'b0000);
      check("rstw_x", player_x, 0);
      check("rstw_y", player_y, 80);
      check("rstw_moving", moving, 0);
      check("rstw_facing", facing, 0);
      check("rstw_anim", anim_frame, 0);
      cycles(GAP);

      // ---------------- simultaneous up+right ----------------
      resp_lat = 1;
      resp_blk = 1'b1;
      set_btn(4'b1001);
      tick_frame();
      set_btn(4'b0000);
      check("prio_facing", facing, 1);
      check("prio_coll_row", coll_bus.coll_row, 4);
      check("prio_coll_col", coll_bus.coll_col, 0);
      cycles(GAP - 1);
      check("prio_y", player_y, 80);

      // ---------------- reset mid-query ----------------
      resp_lat = -1;
      set_btn(4'b0100);
      tick_frame();
      set_btn(4'b0000);
      cycles(3);
      check("rstq_req_before", coll_bus.coll_req, 1);
      reset = 1'b1;
      cycles(1);
      reset = 1'b0;
      check("rstq_req", coll_bus.coll_req, 0);
      check("rstq_facing", facing, 0);
      cycles(GAP);

      // ---------------- randomized run vs frame-level model ----------------
      reset = 1'b1;
      cycles(2);
      reset = 1'b0;
      m_col  = 0;  m_row = 5;  m_face = 0;
      m_walk = 0;  m_steps = 0; m_anim = 0;
      m_fx = 0; m_fy = 0; m_dx = 0; m_dy = 0;
      for (int it = 0; it < 120; it++) begin
         logic [3:0] b;
         int lat, exp_req, nc, nr, dc, dr, ex, ey;
         bit blk;
         b   = ($urandom_range(0, 9) < 2) ? 4'b0000 : 4'($urandom_range(0, 15));
         lat = $urandom_range(0, 17);
         if (lat == 17) lat = -1;
         blk = ($urandom_range(0, 3) == 0);
         resp_lat = lat;
         resp_blk = blk;
         set_btn(b);
         r0 = req_total;
         frame();

         exp_req = 0;
         if (m_walk != 0) begin
            m_steps++;
            if (m_steps * STEP == TILE) begin
               m_walk = 0;
               m_anim = 0;
            end else begin
               m_anim = (m_steps / AT) % 4;
            end
         end else if (b != 4'b0000) begin
            if (b[3])      begin m_face = 1; dc =  0; dr = -1; end
            else if (b[2]) begin m_face = 0; dc =  0; dr =  1; end
            else if (b[1]) begin m_face = 2; dc = -1; dr =  0; end
            else           begin m_face = 3; dc =  1; dr =  0; end
            nc = m_col + dc;
            nr = m_row + dr;
            if (nc >= 0 && nc < COLS && nr >= 0 && nr < ROWS) begin
               bit acked;
               acked   = (lat >= 0) && (lat < TO);
               exp_req = acked ? lat + 1 : TO;
               if (acked && !blk) begin
                  m_fx = m_col * TILE;  m_fy = m_row * TILE;
                  m_dx = dc;            m_dy = dr;
                  m_col = nc;           m_row = nr;
                  m_walk = 1;  m_steps = 0;  m_anim = 0;
               end
            end
         end
         if (m_walk != 0) begin
            ex = m_fx + m_dx * STEP * m_steps;
            ey = m_fy + m_dy * STEP * m_steps;
         end else begin
            ex = m_col * TILE;
            ey = m_row * TILE;
         end
         check($sformatf("rnd%0d_x", it), player_x, ex);
         check($sformatf("rnd%0d_y", it), player_y, ey);
         check($sformatf("rnd%0d_facing", it), facing, m_face);
         check($sformatf("rnd%0d_moving", it), moving, m_walk);
         check($sformatf("rnd%0d_anim", it), anim_frame, m_anim);
         check($sformatf("rnd%0d_req_cycles", it), req_total - r0, exp_req);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
